uart_program_loader: RTL

//  Boot-time stage upstream of the multicycle CPU: takes bytes from uart_rx, assembles
//  big-endian 32-bit words, writes them into the unified instruction/data memory from

---
 rtl/uart_program_loader_pkg.sv | 23 ++
 rtl/uart_program_loader_byte_assembler.sv | 43 ++++
 rtl/uart_program_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM state encoding,
// default response bytes and the length-range helper.
package uart_program_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_ACK  = 3'd2,
        ST_NAK  = 3'd3,
        ST_DONE = 3'd4,
        ST_FAIL = 3'd5
    } state_e;

    localparam int unsigned DEFAULT_ADDR_W   = 15;
    localparam logic [7:0]  DEFAULT_ACK_BYTE = 8'hAA;
    localparam logic [7:0]  DEFAULT_NAK_BYTE = 8'hEE;

    // 33-bit compare so a word count of 32'hFFFFFFFF cannot wrap below capacity.
    function automatic logic len_too_big(input logic [31:0] n, input int unsigned addr_w);
        return ({1'b0, n} > (33'd1 << addr_w));
    endfunction

endpackage

// File: rtl/uart_program_loader_byte_assembler.sv
// Big-endian byte-to-word assembler: keeps the last three bytes and presents the
// full word combinationally together with the strobe of the fourth byte.
module uart_program_loader_byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (strobe) begin
            shift_d = {shift_q[15:0], byte_in};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    assign word       = {shift_q, byte_in};
    assign word_valid = strobe && !clear && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot-time loader: receives a length-prefixed word stream over UART, writes it to
// memory from word 0, answers with ACK/NAK and then releases the CPU or flags an error.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [7:0]  ACK_BYTE = DEFAULT_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE = DEFAULT_NAK_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_ferr,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              err
);

    state_e            state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              cpu_run_q, cpu_run_d;
    logic              err_q, err_d;

    logic        in_frame;
    logic [31:0] asm_word;
    logic        asm_valid;

    assign in_frame = (state_q == ST_LEN) || (state_q == ST_DATA);

    // Bytes flagged with a framing error never reach the assembler; leaving the
    // frame clears it so a partial word is dropped.
    uart_program_loader_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (rx_data),
        .strobe     (rx_ready && !rx_ferr && in_frame),
        .clear      (!in_frame),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;

        case (state_q)
            ST_LEN: begin
                if (rx_ready && rx_ferr) begin
                    state_d = ST_NAK;
                end else if (asm_valid) begin
                    len_d  = asm_word;
                    wcnt_d = '0;
                    if (asm_word == 32'd0)              state_d = ST_ACK;
                    else if (len_too_big(asm_word, ADDR_W)) state_d = ST_NAK;
                    else                                state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // The counter advances in the write cycle; the last write hands over to ACK.
                if (mem_we_q) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (33'(wcnt_q) + 33'd1 == {1'b0, len_q}) state_d = ST_ACK;
                end
                if (asm_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wcnt_q[ADDR_W-1:0];
                    mem_wdata_d = asm_word;
                end
                if (rx_ready && rx_ferr) state_d = ST_NAK;
            end
            ST_ACK: begin
                if (!tx_busy) begin
                    tx_data_d  = ACK_BYTE;
                    tx_start_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_NAK: begin
                if (!tx_busy) begin
                    tx_data_d  = NAK_BYTE;
                    tx_start_d = 1'b1;
                    state_d    = ST_FAIL;
                end
            end
            ST_DONE, ST_FAIL: ;
            default: state_d = ST_LEN;
        endcase

        cpu_run_d = (state_d == ST_DONE);
        err_d     = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LEN;
            len_q       <= '0;
            wcnt_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            cpu_run_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            cpu_run_q   <= cpu_run_d;
            err_q       <= err_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_run   = cpu_run_q;
    assign err       = err_q;

endmodule
